// File: rtl/c_fp_pkg.sv
// c_fp_pkg: shared single-precision field widths, multiplier sizing, product layout and FSM states
package c_fp_pkg;

    localparam int C_BIAS   = 127;
    localparam int C_MANT_W = 24;
    localparam int EXP_W    = 8;
    localparam int FRAC_W   = 23;
    localparam int SIGN_BIT = 31;
    localparam int CNT_W    = 5;
    localparam int ACC_W    = 2 * C_MANT_W;
    // {2'b00, ma*mb, 1'b0}: leading one lands at bit 48 or 47
    localparam int PROD_W   = ACC_W + 3;

    typedef enum logic [1:0] {
        S_IDLE,
        S_UNPACK,
        S_MULT,
        S_DONE
    } state_e;

endpackage

// File: rtl/c_exp_adder.sv
// c_exp_adder: combinational exponent add, bias subtract and clamp to the 9-bit result range
module c_exp_adder
    import c_fp_pkg::*;
#(
    parameter int BIAS = C_BIAS
) (
    input  logic [EXP_W-1:0] ea_i,
    input  logic [EXP_W-1:0] eb_i,
    output logic [EXP_W:0]   exp_o
);

    logic signed [9:0] sum;

    assign sum   = $signed({2'b00, ea_i}) + $signed({2'b00, eb_i}) - $signed(10'(BIAS));
    // a 10-bit signed sum tops out at 511, so only the negative side needs clamping
    assign exp_o = sum[9] ? '0 : sum[8:0];

endmodule

// File: rtl/c_mant_multiplier.sv
// c_mant_multiplier: sequential shift-add mantissa multiplier with sign/exponent unpack;
// define C_MULT_ZERO_BYPASS_EN to skip the multiply loop when an operand is zero
module c_mant_multiplier
    import c_fp_pkg::*;
#(
    parameter int BIAS   = C_BIAS,
    parameter int MANT_W = C_MANT_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [31:0]       a,
    input  logic [31:0]       b,
    output logic              busy,
    output logic              done,
    output logic              sign,
    output logic [PROD_W-1:0] product,
    output logic [EXP_W:0]    new_exponent
);

    state_e              state_q, state_d;
    logic [31:0]         a_q, a_d, b_q, b_d;
    logic [ACC_W-1:0]    acc_q, acc_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                sgn_q, sgn_d, zero_q, zero_d, done_q, done_d, sign_q, sign_d;
    logic [EXP_W:0]      exp_q, exp_d, nexp_q, nexp_d, exp_sum;
    logic [PROD_W-1:0]   prod_q, prod_d;
    logic [C_MANT_W-1:0] mb;
    logic [C_MANT_W:0]   sum;
    logic                zero_op;

    c_exp_adder #(.BIAS(BIAS)) u_exp (
        .ea_i  (a_q[FRAC_W+:EXP_W]),
        .eb_i  (b_q[FRAC_W+:EXP_W]),
        .exp_o (exp_sum)
    );

    assign mb      = {1'b1, b_q[FRAC_W-1:0]};
    assign zero_op = (a_q[FRAC_W+:EXP_W] == '0) || (b_q[FRAC_W+:EXP_W] == '0);
    // accumulator upper half plus multiplicand when the multiplier LSB (held in the lower half) is set
    assign sum     = {1'b0, acc_q[ACC_W-1:C_MANT_W]} + (acc_q[0] ? {1'b0, mb} : '0);

    assign busy         = state_q != S_IDLE;
    assign done         = done_q;
    assign sign         = sign_q;
    assign product      = prod_q;
    assign new_exponent = nexp_q;

    // next-state and datapath: multiplier bits shift out of the accumulator's low half as the product fills in
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        sgn_d   = sgn_q;
        exp_d   = exp_q;
        zero_d  = zero_q;
        done_d  = 1'b0;
        sign_d  = sign_q;
        prod_d  = prod_q;
        nexp_d  = nexp_q;
        case (state_q)
            S_IDLE: begin
                if (start && !done_q) begin
                    state_d = S_UNPACK;
                    a_d     = a;
                    b_d     = b;
                end
            end
            S_UNPACK: begin
                acc_d  = {{C_MANT_W{1'b0}}, 1'b1, a_q[FRAC_W-1:0]};
                cnt_d  = '0;
                sgn_d  = a_q[SIGN_BIT] ^ b_q[SIGN_BIT];
                exp_d  = exp_sum;
                zero_d = zero_op;
`ifdef C_MULT_ZERO_BYPASS_EN
                state_d = zero_op ? S_DONE : S_MULT;
`else
                state_d = S_MULT;
`endif
            end
            S_MULT: begin
                acc_d   = {sum, acc_q[C_MANT_W-1:1]};
                cnt_d   = cnt_q + 1'b1;
                state_d = (cnt_q == CNT_W'(MANT_W - 1)) ? S_DONE : S_MULT;
            end
            S_DONE: begin
                done_d  = 1'b1;
                sign_d  = sgn_q;
                prod_d  = zero_q ? '0 : {2'b00, acc_q, 1'b0};
                nexp_d  = zero_q ? '0 : exp_q;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // state and result registers; reset aborts any operation in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            sgn_q   <= 1'b0;
            exp_q   <= '0;
            zero_q  <= 1'b0;
            done_q  <= 1'b0;
            sign_q  <= 1'b0;
            prod_q  <= '0;
            nexp_q  <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            sgn_q   <= sgn_d;
            exp_q   <= exp_d;
            zero_q  <= zero_d;
            done_q  <= done_d;
            sign_q  <= sign_d;
            prod_q  <= prod_d;
            nexp_q  <= nexp_d;
        end
    end

endmodule

// File: tb/tb_c_mant_multiplier.sv
// tb_c_mant_multiplier: randomized and directed checks of c_mant_multiplier against a behavioural model
module tb_c_mant_multiplier;

    logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0;
    logic [31:0] a = '0, b = '0;
    logic        busy, done, sign;
    logic [50:0] product;
    logic [8:0]  new_exponent;

    int          checks = 0, errors = 0, cyc = 0, start_cyc = 0, m_lat = 26;
    bit          pend = 1'b0;
    logic [50:0] m_prod = '0, h_prod = '0;
    logic [8:0]  m_exp = '0, h_exp = '0;
    logic        m_sign = 1'b0, h_sign = 1'b0;

    c_mant_multiplier dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .a            (a),
        .b            (b),
        .busy         (busy),
        .done         (done),
        .sign         (sign),
        .product      (product),
        .new_exponent (new_exponent)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // reference: exact product of the hidden-bit mantissas, clamped exponent, zero when either exponent field is 0
    function automatic void model(input logic [31:0] x, input logic [31:0] y, output logic [50:0] p,
                                  output logic [8:0] e, output logic s, output int lat);
        int ea = int'(x[30:23]);
        int eb = int'(y[30:23]);
        int t = ea + eb - 127;
        logic [63:0] ma = {40'd0, 1'b1, x[22:0]};
        logic [63:0] mb = {40'd0, 1'b1, y[22:0]};
        bit z = (ea == 0) || (eb == 0);
        s = x[31] ^ y[31];
        p = z ? '0 : 51'((ma * mb) << 1);
        e = z ? '0 : (t < 0 ? 9'd0 : (t > 511 ? 9'd511 : 9'(t)));
`ifdef C_MULT_ZERO_BYPASS_EN
        lat = z ? 2 : 26;
`else
        lat = 26;
`endif
    endfunction

    // compare process: done timing/results against the model, held outputs and busy otherwise
    always @(negedge clk) begin
        if (rst_n) begin
            if (pend && done) begin
                chk("latency", 64'(cyc - start_cyc), 64'(m_lat));
                chk("product", 64'(product), 64'(m_prod));
                chk("new_exponent", 64'(new_exponent), 64'(m_exp));
                chk("sign", 64'(sign), 64'(m_sign));
                h_prod = m_prod;
                h_exp  = m_exp;
                h_sign = m_sign;
                pend   = 1'b0;
            end else begin
                if (!pend) chk("spurious_done", 64'(done), 64'(0));
                chk("hold_product", 64'(product), 64'(h_prod));
                chk("hold_exponent", 64'(new_exponent), 64'(h_exp));
                chk("hold_sign", 64'(sign), 64'(h_sign));
                if (pend && cyc >= start_cyc) chk("busy_active", 64'(busy), 64'(1));
                else if (!pend) chk("busy_idle", 64'(busy), 64'(0));
                if (pend && cyc - start_cyc > m_lat) begin
                    chk("done_timeout", 64'(done), 64'(1));
                    pend = 1'b0;
                end
            end
        end
    end

    task automatic launch(input logic [31:0] x, input logic [31:0] y);
        @(negedge clk);
        a = x;
        b = y;
        start = 1'b1;
        model(x, y, m_prod, m_exp, m_sign, m_lat);
        start_cyc = cyc + 1;
        pend = 1'b1;
    endtask

    task automatic op(input logic [31:0] x, input logic [31:0] y, input bit lit, input logic [50:0] lp,
                      input logic [8:0] le, input logic ls, input bit poke, input bit hold);
        int n = 0;
        launch(x, y);
        if (hold) begin
            @(negedge clk);
            start = 1'b0;
            repeat (m_lat - 1) @(negedge clk);
            @(posedge clk);
            #1;
            start = 1'b1;
            a = $urandom;
            b = $urandom;
            @(posedge clk);
            #1;
            start = 1'b0;
        end
        while (pend && n < 40) begin
            @(negedge clk);
            n++;
            start = poke && n == 5;
            if (start) begin
                a = $urandom;
                b = $urandom;
            end
        end
        start = 1'b0;
        chk("op_complete", 64'(pend), 64'(0));
        if (lit) begin
            chk("lit_model_product", 64'(m_prod), 64'(lp));
            chk("lit_product", 64'(product), 64'(lp));
            chk("lit_exponent", 64'(new_exponent), 64'(le));
            chk("lit_sign", 64'(sign), 64'(ls));
        end
    endtask

    task automatic check_cleared(input string tag);
        chk({tag, "_busy"}, 64'(busy), 64'(0));
        chk({tag, "_done"}, 64'(done), 64'(0));
        chk({tag, "_sign"}, 64'(sign), 64'(0));
        chk({tag, "_product"}, 64'(product), 64'(0));
        chk({tag, "_exponent"}, 64'(new_exponent), 64'(0));
    endtask

    initial begin
        logic [31:0] x, y;
        #1;
        check_cleared("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        op(32'h3F800000, 32'h3F800000, 1, 51'h0800000000000, 9'd127, 1'b0, 0, 0);
        op(32'h3FC00000, 32'h3FC00000, 1, 51'h1200000000000, 9'd127, 1'b0, 0, 0);
        op(32'hC0000000, 32'h40400000, 1, 51'h0C00000000000, 9'd129, 1'b1, 0, 0);
        op(32'h7F000000, 32'h7F000000, 1, 51'h0800000000000, 9'd381, 1'b0, 0, 0);
        op(32'h00800000, 32'h00800000, 1, 51'h0800000000000, 9'd0, 1'b0, 0, 0);
        op(32'h00000000, 32'h3F800000, 1, 51'h0, 9'd0, 1'b0, 0, 0);
        op(32'h40490FDB, 32'hBF000001, 0, '0, '0, 1'b0, 1, 0);
        op(32'h3F800001, 32'h407FFFFF, 0, '0, '0, 1'b0, 0, 1);
        op(32'h80000000, 32'h40000000, 0, '0, '0, 1'b0, 0, 1);

        // abort mid-multiply after an ignored second start
        launch(32'h40000000, 32'h40000000);
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        a = 32'h12345678;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        #2;
        rst_n  = 1'b0;
        pend   = 1'b0;
        h_prod = '0;
        h_exp  = '0;
        h_sign = 1'b0;
        #1;
        check_cleared("abort");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (30) @(negedge clk);
        op(32'h3FC00000, 32'hC0400000, 0, '0, '0, 1'b0, 0, 0);

        for (int i = 0; i < 24; i++) begin
            x = $urandom;
            y = $urandom;
            if ($urandom_range(0, 4) == 0) x[30:23] = 8'd0;
            if ($urandom_range(0, 5) == 0) y[30:23] = 8'd0;
            if ($urandom_range(0, 4) == 0) y[30:23] = 8'($urandom_range(250, 255));
            op(x, y, 0, '0, '0, 1'b0, bit'($urandom_range(0, 1)), bit'($urandom_range(0, 3) == 0));
        end

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
